// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared snake link UART types, widths and opcodes
// Optional parity build: SNAKE_UART_TX_PARITY_EN
package snake_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic [1:0] OP_DIR    = 2'b00;
  localparam logic [1:0] OP_SEED_X = 2'b01;
  localparam logic [1:0] OP_SEED_Y = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SNAKE_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/snake_tx_fifo.sv
// rtl/snake_tx_fifo.sv - synchronous transmit FIFO, head always visible on dout
// Flags derive from the registered occupancy; pushes while full are dropped.
module snake_tx_fifo #(
  parameter int FIFO_AW = 2,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (FIFO_AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/snake_uart_tx.sv
// rtl/snake_uart_tx.sv - snake link UART transmitter: FIFO-buffered 8N1 serializer
// Define SNAKE_UART_TX_PARITY_EN to append an even-parity bit before the stop bit.
module snake_uart_tx
  import snake_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_uart,
  input  logic [UART_DATA_BITS-1:0] w_data,
  output logic                      tx_full,
  output logic                      tx_empty,
  output logic                      tx_busy,
  output logic                      tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      tx_q, tx_d;
  logic                      pop;
  logic                      last;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
`ifdef SNAKE_UART_TX_PARITY_EN
  logic                      par_q, par_d;
`endif

  snake_tx_fifo #(
    .FIFO_AW (FIFO_AW),
    .DW      (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_uart),
    .pop   (pop),
    .din   (w_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign last     = (cnt_q == CNT_MAX);
  assign tx       = tx_q;
  assign tx_full  = fifo_full;
  assign tx_empty = fifo_empty;
  assign tx_busy  = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
`ifdef SNAKE_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
`ifdef SNAKE_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef SNAKE_UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_dout;
`ifdef SNAKE_UART_TX_PARITY_EN
          par_d   = even_parity(fifo_dout);
`endif
          tx_d    = 1'b0;
          state_d = START;
        end else begin
          tx_d = 1'b1;
        end
      end

      START: begin
        if (last) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end
      end

      DATA: begin
        if (last) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
`ifdef SNAKE_UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            // Next bit is shreg[1] now so the line changes on the same edge as the shift.
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end

`ifdef SNAKE_UART_TX_PARITY_EN
      PARITY: begin
        if (last) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (last) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more bytes are waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = fifo_dout;
`ifdef SNAKE_UART_TX_PARITY_EN
            par_d   = even_parity(fifo_dout);
`endif
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        cnt_d   = '0;
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_snake_uart_tx.sv
// tb/tb_snake_uart_tx.sv - scoreboard bench for snake_uart_tx
// Parity checks follow SNAKE_UART_TX_PARITY_EN, matching the DUT build.
module tb_snake_uart_tx;

  localparam int CPB = 4;
  localparam int AW  = 2;
`ifdef SNAKE_UART_TX_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_busy;
  logic       tx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  int         starts[$];
  logic       samp [FRAME];

  snake_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .tx_full  (tx_full),
    .tx_empty (tx_empty),
    .tx_busy  (tx_busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; the write is captured by the following posedge.
  task automatic drive_wr(input logic [7:0] b, input bit accept);
    wr_uart = 1'b1;
    w_data  = b;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_busy && tx_empty) begin
        done = 1;
        break;
      end
    end
    check(tag, done, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (tx_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Frame monitor: samples tx every negedge and scores each completed frame.
  initial begin : monitor
    bit         abort;
    bit         avail;
    logic       hold_ok;
    logic       busy_ok;
    logic [7:0] got;
    logic [7:0] expb;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        abort   = 0;
        starts.push_back(cyc);
        samp[0] = tx;
        busy_ok = tx_busy;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          if (rst) begin
            abort = 1;
            break;
          end
          samp[k] = tx;
          busy_ok = busy_ok & tx_busy;
        end
        if (!abort) begin
          hold_ok = 1'b1;
          for (int j = 0; j < NB; j++)
            for (int m = 0; m < CPB; m++)
              if (samp[j*CPB+m] !== samp[j*CPB]) hold_ok = 1'b0;
          for (int i = 0; i < 8; i++) got[i] = samp[(1+i)*CPB];
          check("bit_hold", hold_ok, 1);
          check("busy_in_frame", busy_ok, 1);
          check("start_bit", samp[0], 0);
          check("stop_bit", samp[(NB-1)*CPB], 1);
          avail = (exp_q.size() != 0);
          check("frame_expected", avail, 1);
          if (avail) begin
            expb = exp_q.pop_front();
            check("frame_data", got, expb);
`ifdef SNAKE_UART_TX_PARITY_EN
            check("parity_bit", samp[9*CPB], ^expb);
`endif
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    int lows;
    rst     = 1'b1;
    wr_uart = 1'b0;
    w_data  = 8'h00;

    // Reset and idle line
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_empty", tx_empty, 1);
    check("rst_full", tx_full, 0);
    check("rst_busy", tx_busy, 0);
    rst = 1'b0;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("idle_high", lows, 0);

    // Single byte: latency and frame length
    drive_wr(8'h41, 1);
    wr_uart = 1'b0;
    check("latency_pre", tx, 1);
    @(negedge clk);
    check("latency_fall", tx, 0);
    check("busy_rise", tx_busy, 1);
    measure_busy(n);
    check("single_busy_len", n, FRAME);
    wait_idle("single_done", 200);

    // Back-to-back frames, no idle gap
    starts.delete();
    drive_wr(8'h81, 1);
    drive_wr(8'h7E, 1);
    wr_uart = 1'b0;
    check("b2b_fall", tx, 0);
    measure_busy(n);
    check("b2b_busy_len", n, 2 * FRAME);
    wait_idle("b2b_done", 300);
    check("b2b_frames", starts.size(), 2);
    if (starts.size() == 2) check("b2b_gap", starts[1] - starts[0], FRAME);

    // Overflow: sixth write dropped
    for (int i = 1; i <= 6; i++) begin
      if (i == 5) check("ovf_not_full", tx_full, 0);
      if (i == 6) check("ovf_full", tx_full, 1);
      drive_wr(8'(i), i <= 5);
    end
    wr_uart = 1'b0;
    wait_idle("ovf_done", 600);
    check("ovf_empty", tx_empty, 1);
    check("ovf_not_full_end", tx_full, 0);

    // Reset mid-frame during data bit 3, with a second byte queued
    drive_wr(8'hA5, 1);
    drive_wr(8'h55, 1);
    wr_uart = 1'b0;
    check("mid_fall", tx, 0);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_empty", tx_empty, 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("mid_no_frame", lows, 0);
    drive_wr(8'h3C, 1);
    wr_uart = 1'b0;
    wait_idle("post_rst_done", 200);

`ifdef SNAKE_UART_TX_PARITY_EN
    // Parity bit and 11-bit frame
    drive_wr(8'h07, 1);
    wr_uart = 1'b0;
    @(negedge clk);
    measure_busy(n);
    check("par_busy_len", n, FRAME);
    wait_idle("par1_done", 200);
    drive_wr(8'h03, 1);
    wr_uart = 1'b0;
    wait_idle("par0_done", 200);
`endif

    check("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
